// File: rtl/mem_dma.sv
// mem_dma: copy/fill initiator for the single-port memory interface.
//
// A start pulse in IDLE latches the operands. Copy mode moves len words from
// src to dst, one word at a time: read request, wait for rresp, write. Fill
// mode writes pattern to len consecutive words at dst, one per cycle. A read
// that sees no rresp within TIMEOUT wait cycles sets the sticky err flag and
// abandons the rest of the transfer.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   start               command strobe, sampled in IDLE only
//   fill                0 = copy, 1 = fill
//   src, dst            word addresses (byte address bits [31:2])
//   len                 word count
//   pattern             fill value
//   busy, done, err     status: not idle / one-cycle completion / read timeout
//   ready, we, addr,
//   wdata, wstrb        memory request side (all zero when ready = 0)
//   rresp, rdata        memory read response
module mem_dma #(
  parameter int LENW    = 16,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            fill,
  input  logic [29:0]     src,
  input  logic [29:0]     dst,
  input  logic [LENW-1:0] len,
  input  logic [31:0]     pattern,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            ready,
  output logic            we,
  output logic [29:0]     addr,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  input  logic            rresp,
  input  logic [31:0]     rdata
);

  localparam int TW = $clog2(TIMEOUT + 1);
  // Last wait cycle index; a missing rresp here expires the read.
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  state_t          state, state_nx;
  logic [29:0]     src_ptr, dst_ptr;
  logic [LENW-1:0] remaining;
  logic            fill_q;
  logic [31:0]     pattern_q;
  logic [31:0]     rbuf;
  logic [TW-1:0]   tcnt;
  logic            err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    we       = 1'b0;
    addr     = '0;
    wdata    = '0;
    wstrb    = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (len == '0)  state_nx = DONE;
          else if (fill)  state_nx = WRITE;
          else            state_nx = READ;
        end
      end
      READ: begin
        ready    = 1'b1;
        addr     = src_ptr;
        state_nx = WAIT;
      end
      WAIT: begin
        if (rresp)              state_nx = WRITE;
        else if (tcnt == TLAST) state_nx = DONE;
      end
      WRITE: begin
        ready = 1'b1;
        we    = 1'b1;
        addr  = dst_ptr;
        wstrb = 4'hf;
        wdata = fill_q ? pattern_q : rbuf;
        if (remaining == LENW'(1)) state_nx = DONE;
        else if (fill_q)           state_nx = WRITE;
        else                       state_nx = READ;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      fill_q    <= 1'b0;
      pattern_q <= '0;
      rbuf      <= '0;
      tcnt      <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            src_ptr   <= src;
            dst_ptr   <= dst;
            remaining <= len;
            fill_q    <= fill;
            pattern_q <= pattern;
            err_q     <= 1'b0;
            tcnt      <= '0;
          end
        end
        // Each read gets its own full timeout window.
        READ: tcnt <= '0;
        WAIT: begin
          if (rresp)              rbuf  <= rdata;
          else if (tcnt == TLAST) err_q <= 1'b1;
          else                    tcnt  <= tcnt + TW'(1);
        end
        WRITE: begin
          remaining <= remaining - LENW'(1);
          dst_ptr   <= dst_ptr + 30'd1;
          if (!fill_q) src_ptr <= src_ptr + 30'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign err  = err_q;

endmodule

// File: doc/mem_dma.md
# mem_dma

Copy/fill initiator for the single-port testbench memory interface: drives `ready`/`we`/`addr`/`wdata`/`wstrb` and consumes `rresp`/`rdata`, so it connects port-for-port to the single-port memory model. On a `start` pulse it either copies `len` words from `src` to `dst` (read, wait for response, write) or fills `len` words at `dst` with a constant pattern. It pre-loads and scrubs memory in benches, and is the reference initiator for exercising the memory model's handshake.

## Interface
- `LENW`, 16, width of the word-count operand.
- `TIMEOUT`, 15, max cycles waited for `rresp` per read (≥1).
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; forces IDLE immediately
- `start`  in  1  single-cycle command strobe, sampled in IDLE only
- `fill`  in  1  0 = copy, 1 = fill; latched at start
- `src`  in  30 `[31:2]`  source word address; latched at start
- `dst`  in  30 `[31:2]`  destination word address; latched at start
- `len`  in  LENW  word count; latched at start
- `pattern`  in  32  fill value; latched at start
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  sticky read-timeout flag, cleared by next accepted start
- `ready`  out  1  memory access request
- `we`  out  1  1 = write, 0 = read; meaningful only with `ready`
- `addr`  out  30 `[31:2]`  word address
- `wdata`  out  32  write data
- `wstrb`  out  4  byte strobes, always 4'hf on writes
- `rresp`  in  1  read response, valid-data strobe
- `rdata`  in  32  read data, sampled only when `rresp`=1 in WAIT

## Operation
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE: `start`=1 latches operands, clears `err`, resets timeout counter. `len`=0 → DONE; `fill`=1 → WRITE; else → READ.
- READ: `ready`=1, `we`=0, `addr`=src_ptr. Always → WAIT next edge.
- WAIT: `ready`=0. `rresp`=1 → capture `rdata` into buf, → WRITE. Else increment timeout counter; counter reaching `TIMEOUT` → set `err`, → DONE, remaining words abandoned.
- WRITE: `ready`=1, `we`=1, `addr`=dst_ptr, `wstrb`=4'hf, `wdata`=buf (copy) or pattern (fill). On edge: remaining−1, dst_ptr+1, src_ptr+1 (copy); remaining reaching 0 → DONE, else → READ (copy) or WRITE (fill).
- DONE: `done`=1 for exactly one cycle, → IDLE.
- Pointers are 30-bit and wrap modulo 2^30 (word 0x3FFFFFFF → 0x00000000); no error.
- When `ready`=0: `we`, `addr`, `wdata`, `wstrb` driven to 0.
- `start` while busy is ignored; the operation in flight is unaffected.
- `rresp` outside WAIT is ignored.
- Overlapping src/dst ranges are copied in ascending address order; no overlap handling.

## Timing
- Reset (async): state IDLE; `busy`, `done`, `err`, `ready`, `we` = 0; `addr`, `wdata`, `wstrb`, buf, pointers, counters = 0. Takes effect without a clock edge, including mid-operation: `ready` drops in the same cycle and no further access is issued.
- Start sampled at edge E0; the first state after IDLE is active in cycle E0+1.
- Copy, memory responding next cycle: 3 cycles per word (READ, WAIT, WRITE), then DONE. `len`=N → `done` in cycle 3N+1 after E0.
- Fill: 1 cycle per word, back-to-back writes. `len`=N → `done` in cycle N+1.
- `len`=0: `done` in cycle 1 and no memory access.
- Timeout: `rresp` low for `TIMEOUT` consecutive WAIT cycles → DONE on the following cycle, with `err`=1 from DONE onward.
- Back-to-back: the earliest new `start` is accepted in the cycle after DONE (IDLE).

## Test plan
- Copy: memory words 0x40..0x43 = 0x11111111, 0x22222222, 0x33333333, 0x44444444; start src=0x40 dst=0x80 len=4 → words 0x80..0x83 match; `done` in cycle 13; `err`=0; exactly 4 reads and 4 writes, all with `wstrb`=4'hf.
- Fill: dst=0x10 len=8 pattern=0xDEADBEEF → 8 consecutive write cycles at 0x10..0x17; no reads; `done` in cycle 9.
- len=0 and busy-start: `len`=0 → `done` in cycle 1 with `ready` never high. A second `start` during a 4-word copy → ignored, first copy completes unchanged.
- Timeout: tie `rresp`=0, copy len=2 → one read at src, 15 WAIT cycles, then `done`=1 with `err`=1 and no write. `err` stays 1 until the next start, which clears it.
- Wrap: copy src=0x3FFFFFFF dst=0x100 len=2 → reads at 0x3FFFFFFF then 0x00000000; writes at 0x100, 0x101.
- Reset mid-copy: assert `reset` during WRITE of word 2 of 4 → `ready`, `busy`, `done` = 0 immediately. After release the block idles, and a new fill completes normally.
